// File: rtl/tile_seq_drawer.sv
// Tile sequence drawer: plays a list of grid tiles as draw, hold, erase
// sweeps of one pixel per cycle on a pixel-write port.
module tile_seq_drawer #(
  parameter int TILE_SIZE = 8,
  parameter int GRID_COLS = 2,
  parameter int GRID_ROWS = 2,
  parameter int SYM_W     = 2,
  parameter int SEQ_LEN   = 9,
  parameter int DWELL     = 4
) (
  input  logic                             clock,
  input  logic                             resetn,
  input  logic                             start,
  input  logic                             abort,
  input  logic                             mode,
  input  logic [SEQ_LEN*SYM_W-1:0]         seq,
  input  logic [$clog2(SEQ_LEN+1)-1:0]     len,
  input  logic [SYM_W-1:0]                 boot_sym,
  output logic [7:0]                       x,
  output logic [7:0]                       y,
  output logic [2:0]                       colour,
  output logic                             plot,
  output logic                             busy,
  output logic                             done,
  output logic [$clog2(SEQ_LEN+1)-1:0]     step
);

  localparam int LW = $clog2(SEQ_LEN+1);
  localparam int PW = (TILE_SIZE > 1) ? $clog2(TILE_SIZE) : 1;
  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int NT = GRID_COLS * GRID_ROWS;
  localparam logic [PW-1:0] PMAX = PW'(TILE_SIZE-1);
  localparam logic [DW-1:0] HMAX = DW'(DWELL-1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_DRAW, S_HOLD, S_ERASE, S_NEXT, S_DONE
  } state_t;

  state_t                     state, nxt;
  logic [SEQ_LEN*SYM_W-1:0]   seq_r;
  logic                       mode_r;
  logic [SYM_W-1:0]           boot_r;
  logic [LW-1:0]              len_r;
  logic [PW-1:0]              px, py;
  logic [DW-1:0]              hold_cnt;
  logic [7:0]                 bx, by;
  logic [2:0]                 col;
  logic [SYM_W-1:0]           sym;
  logic [7:0]                 dx, dy;
  logic [2:0]                 dc;
  logic                       last_px;
  logic                       sweeping;
  int                         sv;

  // Symbols are stored MSB-first within each slot.
  always_comb begin
    sym = '0;
    for (int k = 0; k < SEQ_LEN; k++) begin
      if (step == LW'(k)) begin
        for (int i = 0; i < SYM_W; i++) begin
          sym[SYM_W-1-i] = seq_r[k*SYM_W+i];
        end
      end
    end
    if (mode_r) sym = boot_r;
    sv = int'(sym);
    dx = '0;
    dy = '0;
    dc = 3'b111;
    if (sv < NT) begin
      dx = 8'((sv % GRID_COLS) * TILE_SIZE);
      dy = 8'((sv / GRID_COLS) * TILE_SIZE);
      dc = 3'(sv + 1);
    end
  end

  assign last_px  = (px == PMAX) && (py == PMAX);
  assign sweeping = (state == S_DRAW) || (state == S_ERASE);

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:  if (start) nxt = S_LOAD;
      S_LOAD:  nxt = (!mode_r && len_r == '0) ? S_DONE : S_DRAW;
      S_DRAW:  if (last_px) nxt = S_HOLD;
      S_HOLD:  if (hold_cnt == HMAX) nxt = S_ERASE;
      S_ERASE: if (last_px) nxt = S_NEXT;
      S_NEXT:  nxt = (mode_r || (step + LW'(1)) >= len_r) ? S_DONE : S_LOAD;
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
    if (abort && state != S_IDLE) nxt = S_IDLE;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state    <= S_IDLE;
      seq_r    <= '0;
      mode_r   <= 1'b0;
      boot_r   <= '0;
      len_r    <= '0;
      step     <= '0;
      px       <= '0;
      py       <= '0;
      hold_cnt <= '0;
      bx       <= '0;
      by       <= '0;
      col      <= '0;
    end else begin
      state <= nxt;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            seq_r  <= seq;
            mode_r <= mode;
            boot_r <= boot_sym;
            len_r  <= (len > LW'(SEQ_LEN)) ? LW'(SEQ_LEN) : len;
            step   <= '0;
          end
        end
        S_LOAD: begin
          bx <= dx;
          by <= dy;
          col <= dc;
          px <= '0;
          py <= '0;
        end
        S_DRAW, S_ERASE: begin
          hold_cnt <= '0;
          if (px == PMAX) begin
            px <= '0;
            py <= (py == PMAX) ? '0 : py + PW'(1);
          end else begin
            px <= px + PW'(1);
          end
        end
        S_HOLD: hold_cnt <= hold_cnt + DW'(1);
        S_NEXT: step <= step + LW'(1);
        default: ;
      endcase
    end
  end

  assign plot   = sweeping;
  assign x      = sweeping ? bx + 8'(px) : 8'd0;
  assign y      = sweeping ? by + 8'(py) : 8'd0;
  assign colour = (state == S_DRAW) ? col : 3'b000;
  assign busy   = (state != S_IDLE);
  assign done   = (state == S_DONE);

endmodule
